mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single atomic memory controller between N_REQ
//  requesters (harts or I/D ports). It grants one requester at a time and holds the
//  grant until the controller returns ack. It muxes that requester's bus and atomic
//  fields downstream, driving o_id so LR/SC reservations are tracked per requester.
//  It routes ack and read data back to the granted requester only.
// PARAMETERS
//  N_REQ  2  number of requesters (>=2)
//  ID_W   (N_REQ>1 ? $clog2(N_REQ) : 1)  width of o_id (localparam)
// PORTS
//  i_clk            in   1          clock
//  i_rst            in   1          reset, asynchronous, active-high
//  i_req_bus_en     in   N_REQ      per-requester transaction request
//  i_req_wr_en      in   N_REQ      per-requester write enable
//  i_req_wr_data    in   32*N_REQ   write data, requester k at [32k+31:32k]
//  i_req_addr       in   32*N_REQ   byte address, same packing
//  i_req_byte_en    in   4*N_REQ    byte enables, requester k at [4k+3:4k]
//  i_req_atomic     in   N_REQ      atomic access flag
//  i_req_operation  in   7*N_REQ    atomic funct bits [6:0], requester k at [7k+6:7k]
//  o_req_ack        out  N_REQ      one-hot ack to the granted requester
//  o_req_rd_data    out  32         read data (broadcast; valid with o_req_ack)
//  o_bus_en         out  1          to controller: request
//  o_wr_en, o_wr_data[31:0], o_addr[31:0], o_byte_en[3:0]   out  to controller: muxed fields
//  o_atomic         out  1          to controller: muxed atomic flag
//  o_operation      out  7          to controller: muxed operation
//  o_id             out  ID_W       to controller: index of granted requester
//  i_ack            in   1          from controller: transaction complete
//  i_rd_data        in   32         from controller: read data / SC result
//  o_grant          out  N_REQ      one-hot current grant (debug/perf)
// BEHAVIOUR
//  - FSM states: IDLE, BUSY, RELEASE. The grant index and RR pointer are registered.
//  - IDLE: if any i_req_bus_en is set, select the first set bit searching from ptr
//    upward with wrap-around. Register grant=winner and ptr=(winner+1)%N_REQ, then go to BUSY.
//    Otherwise stay in IDLE.
//  - BUSY:
//    - o_bus_en = i_req_bus_en[grant].
//    - All downstream fields are combinational muxes of the granted requester.
//    - o_id = grant.
//    - On i_ack: o_req_ack[grant]=1 and o_req_rd_data=i_rd_data in the same cycle,
//      then go to RELEASE.
//  - RELEASE: one bubble cycle with o_bus_en=0 and no arbitration, so the requester
//    drops bus_en. Then go to IDLE.
//  - Latency:
//    - request at cycle t -> o_bus_en at t+1.
//    - ack at cycle a -> next grant earliest at a+2, next o_bus_en at a+3.
//  - Outside BUSY, all downstream outputs and o_req_ack are 0. i_ack outside BUSY is ignored.
//  - The grant is held through the whole transaction, including AMO FETCH/EX/STORE
//    sequences. Dropping i_req_bus_en mid-BUSY is a protocol error. The grant is still
//    held until i_ack.
//  - Requests from non-granted requesters are held pending and never acked.
//  - Reset (async, any state): state=IDLE, grant=0, ptr=0. All outputs return to 0
//    immediately. An ack arriving for an in-flight transaction is lost.
//  - Simultaneous new request and i_ack in BUSY: the new request is evaluated only in
//    IDLE (after RELEASE).
// TESTING (N_REQ=2)
//  1. Requester 0 reads 0x100. In BUSY expect o_bus_en=1, o_addr=0x100, o_id=0. Drive
//     i_ack with i_rd_data=0xDEADBEEF: o_req_ack=2'b01 and o_req_rd_data=0xDEADBEEF
//     that cycle; o_bus_en=0 on the next cycle.
//  2. Both requesters assert together after reset. Expect requester 0 served, RELEASE,
//     then requester 1 served with o_id=1 and o_req_ack=2'b10.
//  3. Both requesters hold bus_en continuously for 4 transactions. Grant sequence is
//     exactly 0,1,0,1.
//  4. Requester 1 issues AMOADD (atomic=1, operation=7'h00) with wr_data 0x5. Expect
//     o_atomic=1, o_operation=7'h00, o_id=1, and o_wr_data=0x5 held until i_ack.
//  5. i_ack=1 pulsed while in IDLE: o_req_ack stays 0 and the FSM stays in IDLE.
//  6. Assert i_rst while in BUSY. o_bus_en and o_grant drop to 0 without waiting for a
//     clock edge. After release, requester 1 alone wins first; it is found from ptr=0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between N_REQ requesters, the round-robin arbiter and the atomic memory controller.
// The master modport is the arbiter's view; slave is the requester/controller environment.
interface mem_bus_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    i_req_bus_en;
  logic [N_REQ-1:0]    i_req_wr_en;
  logic [32*N_REQ-1:0] i_req_wr_data;
  logic [32*N_REQ-1:0] i_req_addr;
  logic [4*N_REQ-1:0]  i_req_byte_en;
  logic [N_REQ-1:0]    i_req_atomic;
  logic [7*N_REQ-1:0]  i_req_operation;
  logic [N_REQ-1:0]    o_req_ack;
  logic [31:0]         o_req_rd_data;

  logic                o_bus_en;
  logic                o_wr_en;
  logic [31:0]         o_wr_data;
  logic [31:0]         o_addr;
  logic [3:0]          o_byte_en;
  logic                o_atomic;
  logic [6:0]          o_operation;
  logic [ID_W-1:0]     o_id;
  logic                i_ack;
  logic [31:0]         i_rd_data;
  logic [N_REQ-1:0]    o_grant;

  modport master (
    input  i_req_bus_en, i_req_wr_en, i_req_wr_data, i_req_addr, i_req_byte_en,
    input  i_req_atomic, i_req_operation, i_ack, i_rd_data,
    output o_req_ack, o_req_rd_data, o_bus_en, o_wr_en, o_wr_data, o_addr,
    output o_byte_en, o_atomic, o_operation, o_id, o_grant
  );

  modport slave (
    output i_req_bus_en, i_req_wr_en, i_req_wr_data, i_req_addr, i_req_byte_en,
    output i_req_atomic, i_req_operation, i_ack, i_rd_data,
    input  o_req_ack, o_req_rd_data, o_bus_en, o_wr_en, o_wr_data, o_addr,
    input  o_byte_en, o_atomic, o_operation, o_id, o_grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter in front of the shared atomic memory controller. The grant is held
// until the controller acks, followed by one RELEASE bubble so the winner can drop bus_en.
module mem_bus_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_bus_arbiter_if.master bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_grant_nxt;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_idx;
  logic            w_any;
  logic            w_busy;

  // Scan offsets from high to low so the set bit nearest r_ptr (with wrap) wins last.
  always_comb begin
    w_any    = |bus.i_req_bus_en;
    w_winner = {ID_W{1'b0}};
    w_idx    = {ID_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (bus.i_req_bus_en[w_idx]) begin
        w_winner = w_idx;
      end else begin
        w_winner = w_winner;
      end
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_grant <= {ID_W{1'b0}};
      r_ptr   <= {ID_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic; arbitration happens only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_winner;
          w_ptr_nxt   = (w_winner == LAST_IDX) ? {ID_W{1'b0}} : (w_winner + ID_W'(1));
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.i_ack) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Downstream muxes and ack routing; everything is forced to zero outside BUSY.
  always_comb begin
    w_busy            = (r_state == ST_BUSY);
    bus.o_bus_en      = 1'b0;
    bus.o_wr_en       = 1'b0;
    bus.o_wr_data     = 32'd0;
    bus.o_addr        = 32'd0;
    bus.o_byte_en     = 4'd0;
    bus.o_atomic      = 1'b0;
    bus.o_operation   = 7'd0;
    bus.o_id          = {ID_W{1'b0}};
    bus.o_grant       = {N_REQ{1'b0}};
    bus.o_req_ack     = {N_REQ{1'b0}};
    bus.o_req_rd_data = 32'd0;
    if (w_busy) begin
      bus.o_bus_en    = bus.i_req_bus_en[r_grant];
      bus.o_wr_en     = bus.i_req_wr_en[r_grant];
      bus.o_wr_data   = bus.i_req_wr_data[{r_grant, 5'd0} +: 32];
      bus.o_addr      = bus.i_req_addr[{r_grant, 5'd0} +: 32];
      bus.o_byte_en   = bus.i_req_byte_en[{r_grant, 2'd0} +: 4];
      bus.o_atomic    = bus.i_req_atomic[r_grant];
      bus.o_operation = bus.i_req_operation[int'(r_grant) * 7 +: 7];
      bus.o_id        = r_grant;
      bus.o_grant     = {{(N_REQ - 1){1'b0}}, 1'b1} << r_grant;
      if (bus.i_ack) begin
        bus.o_req_ack     = {{(N_REQ - 1){1'b0}}, 1'b1} << r_grant;
        bus.o_req_rd_data = bus.i_rd_data;
      end else begin
        bus.o_req_ack     = {N_REQ{1'b0}};
        bus.o_req_rd_data = 32'd0;
      end
    end else begin
      bus.o_bus_en = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run checked cycle by cycle against a
// transaction-level model (owner / release gap / rotating pointer).
module tb_mem_bus_arbiter;
  localparam int N    = 2;
  localparam int IDW  = 1;
  localparam int DW   = 78 + IDW;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  int   m_owner;
  bit   m_gap;
  int   m_ptr;
  logic [DW-1:0]  e_down;
  logic [N-1:0]   e_ack;
  logic [N-1:0]   e_grant;
  logic [31:0]    e_rd;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.N_REQ(N)) bus ();
  mem_bus_arbiter #(.N_REQ(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.i_req_bus_en = '0; bus.i_req_wr_en = '0; bus.i_req_wr_data = '0;
    bus.i_req_addr = '0; bus.i_req_byte_en = '0; bus.i_req_atomic = '0;
    bus.i_req_operation = '0; bus.i_ack = 1'b0; bus.i_rd_data = 32'd0;
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 1'b0; m_ptr = 0;
  endtask

  // One transaction owner at a time, one idle gap after each ack, pointer rotates past the winner.
  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (bus.i_ack) begin m_owner = -1; m_gap = 1'b1; end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bus.i_req_bus_en[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
    end
  endtask

  task automatic model_expect();
    e_down = '0; e_ack = '0; e_grant = '0; e_rd = 32'd0;
    if (m_owner >= 0) begin
      e_down = {bus.i_req_bus_en[m_owner], bus.i_req_wr_en[m_owner],
                bus.i_req_wr_data[32*m_owner +: 32], bus.i_req_addr[32*m_owner +: 32],
                bus.i_req_byte_en[4*m_owner +: 4], bus.i_req_atomic[m_owner],
                bus.i_req_operation[7*m_owner +: 7], IDW'(m_owner)};
      e_grant = N'(1) << m_owner;
      if (bus.i_ack) begin
        e_ack = N'(1) << m_owner;
        e_rd  = bus.i_rd_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_bus_en !== 1'b0) begin n_fail++; $display("FAIL reset_bus_en: got %0h want 0", bus.o_bus_en); end
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %0h want 0", bus.o_grant); end
    n_cmp++; if (bus.o_req_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %0h want 0", bus.o_req_ack); end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.i_req_bus_en[0] = 1'b1; bus.i_req_addr[31:0] = 32'h100; bus.i_req_byte_en[3:0] = 4'hF;
    #1;
    n_cmp++; if (bus.o_bus_en !== 1'b0) begin n_fail++; $display("FAIL rd_req_cycle_bus_en: got %0h want 0", bus.o_bus_en); end
    tick();
    n_cmp++; if (bus.o_bus_en !== 1'b1) begin n_fail++; $display("FAIL rd_bus_en: got %0h want 1", bus.o_bus_en); end
    n_cmp++; if (bus.o_addr !== 32'h100) begin n_fail++; $display("FAIL rd_addr: got %0h want 100", bus.o_addr); end
    n_cmp++; if (bus.o_id !== 1'b0) begin n_fail++; $display("FAIL rd_id: got %0h want 0", bus.o_id); end
    bus.i_ack = 1'b1; bus.i_rd_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (bus.o_req_ack !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got %0h want 1", bus.o_req_ack); end
    n_cmp++; if (bus.o_req_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %0h want deadbeef", bus.o_req_rd_data); end
    tick();
    bus.i_ack = 1'b0; bus.i_req_bus_en[0] = 1'b0;
    #1;
    n_cmp++; if (bus.o_bus_en !== 1'b0) begin n_fail++; $display("FAIL rd_release_bus_en: got %0h want 0", bus.o_bus_en); end
    n_cmp++; if (bus.o_req_ack !== 2'b00) begin n_fail++; $display("FAIL rd_release_ack: got %0h want 0", bus.o_req_ack); end
    tick(); tick();
  endtask

  task automatic test_both_requesters();
    do_reset();
    bus.i_req_bus_en = 2'b11; bus.i_req_addr = {32'h300, 32'h200};
    tick();
    n_cmp++; if (bus.o_id !== 1'b0) begin n_fail++; $display("FAIL both_first_id: got %0h want 0", bus.o_id); end
    n_cmp++; if (bus.o_addr !== 32'h200) begin n_fail++; $display("FAIL both_first_addr: got %0h want 200", bus.o_addr); end
    bus.i_ack = 1'b1;
    #1;
    n_cmp++; if (bus.o_req_ack !== 2'b01) begin n_fail++; $display("FAIL both_first_ack: got %0h want 1", bus.o_req_ack); end
    tick();
    bus.i_ack = 1'b0; bus.i_req_bus_en[0] = 1'b0;
    #1;
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL both_release_grant: got %0h want 0", bus.o_grant); end
    tick();
    n_cmp++; if (bus.o_bus_en !== 1'b0) begin n_fail++; $display("FAIL both_idle_bus_en: got %0h want 0", bus.o_bus_en); end
    tick();
    n_cmp++; if (bus.o_id !== 1'b1) begin n_fail++; $display("FAIL both_second_id: got %0h want 1", bus.o_id); end
    n_cmp++; if (bus.o_addr !== 32'h300) begin n_fail++; $display("FAIL both_second_addr: got %0h want 300", bus.o_addr); end
    bus.i_ack = 1'b1;
    #1;
    n_cmp++; if (bus.o_req_ack !== 2'b10) begin n_fail++; $display("FAIL both_second_ack: got %0h want 2", bus.o_req_ack); end
    tick();
    drive_idle();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [IDW-1:0] seq[$];
    logic [IDW-1:0] want[4];
    want[0] = 1'b0; want[1] = 1'b1; want[2] = 1'b0; want[3] = 1'b1;
    do_reset();
    bus.i_req_bus_en = 2'b11;
    for (int c = 0; c < 60 && seq.size() < 4; c++) begin
      bus.i_ack = bus.o_bus_en;
      #1;
      if (bus.o_req_ack != 2'b00) seq.push_back(bus.o_id);
      tick();
    end
    drive_idle();
    n_cmp++; if (seq.size() !== 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", seq.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < seq.size()) begin
        n_cmp++; if (seq[i] !== want[i]) begin n_fail++; $display("FAIL rr_seq[%0d]: got %0h want %0h", i, seq[i], want[i]); end
      end
    end
    tick(); tick();
  endtask

  task automatic test_amo();
    do_reset();
    bus.i_req_wr_data = {32'h5, 32'hAAAA_AAAA}; bus.i_req_operation = {7'h00, 7'h7F};
    bus.i_req_atomic = 2'b10; bus.i_req_wr_en = 2'b10; bus.i_req_bus_en = 2'b10;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({bus.o_atomic, bus.o_operation, bus.o_id, bus.o_wr_data} !== {1'b1, 7'h00, 1'b1, 32'h5}) begin
        n_fail++; $display("FAIL amo_fields[%0d]: got %0h want %0h", c,
                           {bus.o_atomic, bus.o_operation, bus.o_id, bus.o_wr_data}, {1'b1, 7'h00, 1'b1, 32'h5});
      end
      n_cmp++; if (bus.o_req_ack !== 2'b00) begin n_fail++; $display("FAIL amo_early_ack: got %0h want 0", bus.o_req_ack); end
      tick();
    end
    bus.i_ack = 1'b1;
    #1;
    n_cmp++; if (bus.o_req_ack !== 2'b10) begin n_fail++; $display("FAIL amo_ack: got %0h want 2", bus.o_req_ack); end
    tick();
    drive_idle();
    #1;
    n_cmp++; if (bus.o_atomic !== 1'b0) begin n_fail++; $display("FAIL amo_release_atomic: got %0h want 0", bus.o_atomic); end
    tick(); tick();
  endtask

  task automatic test_ack_idle();
    do_reset();
    bus.i_ack = 1'b1;
    #1;
    n_cmp++; if (bus.o_req_ack !== 2'b00) begin n_fail++; $display("FAIL idle_ack: got %0h want 0", bus.o_req_ack); end
    tick();
    bus.i_ack = 1'b0; bus.i_req_bus_en[0] = 1'b1;
    #1;
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL idle_grant: got %0h want 0", bus.o_grant); end
    tick();
    n_cmp++; if (bus.o_bus_en !== 1'b1) begin n_fail++; $display("FAIL idle_then_grant: got %0h want 1", bus.o_bus_en); end
    bus.i_ack = 1'b1;
    tick();
    drive_idle();
    tick(); tick();
  endtask

  task automatic test_reset_busy();
    do_reset();
    bus.i_req_bus_en[0] = 1'b1;
    tick();
    n_cmp++; if (bus.o_bus_en !== 1'b1) begin n_fail++; $display("FAIL rstb_pre_bus_en: got %0h want 1", bus.o_bus_en); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_bus_en !== 1'b0) begin n_fail++; $display("FAIL rstb_async_bus_en: got %0h want 0", bus.o_bus_en); end
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL rstb_async_grant: got %0h want 0", bus.o_grant); end
    tick();
    rst = 1'b0; model_reset();
    bus.i_req_bus_en = 2'b10;
    tick();
    n_cmp++; if (bus.o_id !== 1'b1) begin n_fail++; $display("FAIL rstb_after_id: got %0h want 1", bus.o_id); end
    n_cmp++; if (bus.o_grant !== 2'b10) begin n_fail++; $display("FAIL rstb_after_grant: got %0h want 2", bus.o_grant); end
    bus.i_ack = 1'b1;
    tick();
    drive_idle();
    tick(); tick();
  endtask

  task automatic test_random();
    bit pend[N];
    bit acked[N];
    do_reset();
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          bus.i_req_bus_en[k] = 1'b1;
          bus.i_req_wr_en[k] = 1'($urandom);
          bus.i_req_atomic[k] = 1'($urandom);
          bus.i_req_wr_data[32*k +: 32] = $urandom;
          bus.i_req_addr[32*k +: 32] = $urandom;
          bus.i_req_byte_en[4*k +: 4] = 4'($urandom);
          bus.i_req_operation[7*k +: 7] = 7'($urandom);
        end
      end
      bus.i_ack = ($urandom_range(0, 2) == 0);
      bus.i_rd_data = $urandom;
      #1;
      model_expect();
      n_cmp++; if ({bus.o_bus_en, bus.o_wr_en, bus.o_wr_data, bus.o_addr, bus.o_byte_en, bus.o_atomic, bus.o_operation, bus.o_id} !== e_down) begin
        n_fail++; $display("FAIL rand_down[%0d]: got %0h want %0h", c,
                           {bus.o_bus_en, bus.o_wr_en, bus.o_wr_data, bus.o_addr, bus.o_byte_en, bus.o_atomic, bus.o_operation, bus.o_id}, e_down);
      end
      n_cmp++; if (bus.o_req_ack !== e_ack) begin n_fail++; $display("FAIL rand_ack[%0d]: got %0h want %0h", c, bus.o_req_ack, e_ack); end
      n_cmp++; if (bus.o_req_rd_data !== e_rd) begin n_fail++; $display("FAIL rand_rd[%0d]: got %0h want %0h", c, bus.o_req_rd_data, e_rd); end
      n_cmp++; if (bus.o_grant !== e_grant) begin n_fail++; $display("FAIL rand_grant[%0d]: got %0h want %0h", c, bus.o_grant, e_grant); end
      for (int k = 0; k < N; k++) acked[k] = e_ack[k];
      tick();
      for (int k = 0; k < N; k++) begin
        if (acked[k]) begin pend[k] = 1'b0; bus.i_req_bus_en[k] = 1'b0; end
      end
    end
    drive_idle();
    tick(); tick();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_both_requesters();
    test_back_to_back();
    test_amo();
    test_ack_idle();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
